// File: rtl/fpu_div_ctrl.sv
// fpu_div_ctrl: multi-cycle single-precision divider. Computes 1/b by
// Newton-Raphson from a 256-entry reciprocal seed table, then q = a * (1/b).
// One multiplier and one adder are time-shared across all steps.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid / o_ready   request handshake; i_a, i_b operands (IEEE-754 single)
//   o_valid / i_ready   result handshake; o_result quotient, o_flags {NV,DZ,OF,UF}
module fpu_div_ctrl #(
  parameter int unsigned ITER = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic [3:0]  o_flags
);
  localparam int unsigned CNT_W = 2;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
  localparam logic [31:0] TWO   = 32'h4000_0000;
  localparam logic [1:0]  MUL_BX = 2'd0;
  localparam logic [1:0]  MUL_XT = 2'd1;
  localparam logic [1:0]  MUL_AX = 2'd2;

  typedef enum logic [2:0] {IDLE, CHK, NR_AX, NR_SUB, NR_XT, QMUL, EXP, DONE} state_t;

  // Seed table: top 8 fraction bits of 1/(1 + (i+0.5)/256) in [0.5,1)
  function automatic logic [2047:0] gen_lut();
    logic [2047:0] r;
    r = '0;
    for (int i = 0; i < 256; i++)
      r[i*8 +: 8] = 8'((32'd262144 / (32'd513 + 32'(2 * i))) - 32'd256);
    return r;
  endfunction
  localparam logic [2047:0] LUT = gen_lut();

  // Multiply of two normal operands, round to nearest even
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [7:0]  e;
    logic [22:0] f;
    logic        rnd;
    logic [23:0] fr;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = a[30:23] + b[30:23] - 8'd127;
    if (p[47]) begin
      f   = p[46:24];
      rnd = p[23] & ((|p[22:0]) | p[24]);
      e   = e + 8'd1;
    end else begin
      f   = p[45:23];
      rnd = p[22] & ((|p[21:0]) | p[23]);
    end
    fr = {1'b0, f} + 24'(rnd);
    if (fr[23]) e = e + 8'd1;
    return {a[31] ^ b[31], e, fr[22:0]};
  endfunction

  // Add of two normal operands, round to nearest even, exact zero on cancel
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml, r;
    logic [7:0]  d, e;
    logic [48:0] mb, ms, s;
    logic [47:0] n;
    logic [5:0]  lead;
    logic        rnd;
    logic [23:0] fr;
    if (a[30:0] >= b[30:0]) begin
      big = a; sml = b;
    end else begin
      big = b; sml = a;
    end
    d  = big[30:23] - sml[30:23];
    mb = {2'b01, big[22:0], 24'd0};
    ms = {2'b01, sml[22:0], 24'd0} >> d;
    s  = (big[31] == sml[31]) ? mb + ms : mb - ms;
    lead = 6'd0;
    for (int i = 0; i < 49; i++)
      if (s[i]) lead = 6'(i);
    // leading one moves to bit 48 and drops out; n holds fraction + round bits
    n   = 48'(s << (6'd48 - lead));
    e   = big[30:23] + 8'(lead) - 8'd47;
    rnd = n[24] & ((|n[23:0]) | n[25]);
    fr  = {1'b0, n[47:25]} + 24'(rnd);
    if (fr[23]) e = e + 8'd1;
    r = {big[31], e, fr[22:0]};
    if (s == '0) r = '0;
    return r;
  endfunction

  state_t           state, state_nxt;
  logic [31:0]      a_q, b_q, x, m, t;
  logic [30:0]      q;
  logic [CNT_W-1:0] cnt;
  logic             special;
  logic [1:0]       mul_sel;
  logic             ld_chk, ld_m, ld_t, ld_x, ld_q, ld_exp;
  logic [31:0]      mul_a, mul_b, mul_res, add_res, an, bn, seed;
  logic             accept, last_iter, sgn;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             spec_hit;
  logic [31:0]      spec_res;
  logic [3:0]       spec_flags;
  logic [9:0]       e_c;

  assign accept    = (state == IDLE) && i_valid;
  assign last_iter = (32'(cnt) + 32'd1) >= ITER;
  assign sgn       = a_q[31] ^ b_q[31];
  assign an        = {1'b0, 8'd127, a_q[22:0]};
  assign bn        = {1'b0, 8'd127, b_q[22:0]};
  assign seed      = {1'b0, 8'd126, LUT[{b_q[22:15], 3'b000} +: 8], 15'd0};

  // Operand classes; exponent 0 is treated as zero (subnormals flushed)
  assign a_zero = a_q[30:23] == 8'd0;
  assign b_zero = b_q[30:23] == 8'd0;
  assign a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);

  // Special-case result in priority order
  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = QNAN;
    spec_flags = 4'b1000;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_res   = QNAN;
      spec_flags = 4'b1000;
    end else if (b_zero) begin
      spec_res   = {sgn, 8'hFF, 23'd0};
      spec_flags = 4'b0100;
    end else if (a_inf) begin
      spec_res   = {sgn, 8'hFF, 23'd0};
      spec_flags = 4'b0000;
    end else if (b_inf || a_zero) begin
      spec_res   = {sgn, 31'd0};
      spec_flags = 4'b0000;
    end else begin
      spec_hit   = 1'b0;
      spec_res   = '0;
      spec_flags = '0;
    end
  end

  // Shared multiplier operand mux and the single adder use (2 - m)
  always_comb begin
    mul_a = bn;
    mul_b = x;
    case (mul_sel)
      MUL_XT: begin mul_a = x;  mul_b = t; end
      MUL_AX: begin mul_a = an; mul_b = x; end
      default: ;
    endcase
  end
  assign mul_res = fp_mul(mul_a, mul_b);
  assign add_res = fp_add(TWO, {~m[31], m[30:0]});

  // Result exponent as 10-bit signed: q exponent + ea - eb
  assign e_c = 10'(q[30:23]) + 10'(a_q[30:23]) - 10'(b_q[30:23]);

  // State register; o_ready/o_valid registered from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_ready <= state_nxt == IDLE;
      o_valid <= state_nxt == DONE;
    end
  end

  // Next-state logic; special results pass through EXP so both paths share its timing
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = CHK;
      CHK:     state_nxt = spec_hit ? EXP : NR_AX;
      NR_AX:   state_nxt = NR_SUB;
      NR_SUB:  state_nxt = NR_XT;
      NR_XT:   state_nxt = last_iter ? QMUL : NR_AX;
      QMUL:    state_nxt = EXP;
      EXP:     state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath control decode
  always_comb begin
    mul_sel = MUL_BX;
    ld_chk  = 1'b0;
    ld_m    = 1'b0;
    ld_t    = 1'b0;
    ld_x    = 1'b0;
    ld_q    = 1'b0;
    ld_exp  = 1'b0;
    case (state)
      CHK:    ld_chk = 1'b1;
      NR_AX:  ld_m   = 1'b1;
      NR_SUB: ld_t   = 1'b1;
      NR_XT:  begin mul_sel = MUL_XT; ld_x = 1'b1; end
      QMUL:   begin mul_sel = MUL_AX; ld_q = 1'b1; end
      EXP:    ld_exp = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      x        <= '0;
      m        <= '0;
      t        <= '0;
      q        <= '0;
      cnt      <= '0;
      special  <= 1'b0;
      o_result <= '0;
      o_flags  <= '0;
    end else begin
      if (accept) begin
        a_q     <= i_a;
        b_q     <= i_b;
        cnt     <= '0;
        special <= 1'b0;
        o_flags <= '0;
      end
      if (ld_chk) begin
        special <= spec_hit;
        x       <= seed;
        if (spec_hit) begin
          o_result <= spec_res;
          o_flags  <= spec_flags;
        end
      end
      if (ld_m) m <= mul_res;
      if (ld_t) t <= add_res;
      if (ld_x) begin
        x   <= mul_res;
        cnt <= cnt + CNT_W'(1);
      end
      if (ld_q) q <= mul_res[30:0];
      if (ld_exp && !special) begin
        if ($signed(e_c) >= 10'sd255) begin
          o_result <= {sgn, 8'hFF, 23'd0};
          o_flags  <= 4'b0010;
        end else if ($signed(e_c) <= 10'sd0) begin
          o_result <= {sgn, 31'd0};
          o_flags  <= 4'b0001;
        end else begin
          o_result <= {sgn, e_c[7:0], q[22:0]};
          o_flags  <= 4'b0000;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_div_ctrl.sv
// Directed bench for fpu_div_ctrl: latency, results, flags, stall and reset.
module tb_fpu_div_ctrl;
  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_ready;
  logic [31:0] i_a, i_b;
  logic        o_ready, o_valid;
  logic [31:0] o_result;
  logic [3:0]  o_flags;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_div_ctrl #(.ITER(2)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_flags(o_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for o_valid; lat = edges after accept
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     output int lat, output logic [31:0] res, output logic [3:0] flg);
    i_a = a;
    i_b = b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 40) begin
      tick();
      lat++;
    end
    res = o_result;
    flg = o_flags;
  endtask

  // Run a vector with i_ready = 1 and check latency, result and flags
  task automatic vec(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input logic [3:0] exp_flg, input int exp_lat);
    int lat;
    logic [31:0] res;
    logic [3:0]  flg;
    check({name, "_ready"}, 32'(o_ready), 32'd1);
    run(a, b, lat, res, flg);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_res"}, res, exp_res);
    check({name, "_flags"}, 32'(flg), 32'(exp_flg));
    tick();
  endtask

  initial begin
    int lat;
    logic [31:0] res, held_res;
    logic [3:0]  flg, held_flg;

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_a = '0; i_b = '0;
    tick();
    tick();
    i_rst = 1'b0;
    check("rst_ready",  32'(o_ready), 32'd1);
    check("rst_valid",  32'(o_valid), 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_flags",  32'(o_flags), 32'd0);

    // Normal divides: 9 edges for ITER=2
    vec("div_6_2",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 9);
    vec("div_m6_2",  32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000, 9);
    vec("ovf",       32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b0010, 9);
    vec("unf",       32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 4'b0001, 9);
    // Special cases: 2 edges
    vec("x_div_0",   32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100, 2);
    vec("z_div_z",   32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 2);
    vec("nan_a",     32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 2);
    vec("inf_inf",   32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000, 2);
    vec("inf_div_x", 32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 4'b0000, 2);
    vec("x_div_inf", 32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 4'b0000, 2);
    vec("subn_a",    32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 2);

    // 1/3 within 2 ulp of 0x3EAAAAAB
    run(32'h3F80_0000, 32'h4040_0000, lat, res, flg);
    check("third_lat", 32'(lat), 32'd9);
    check("third_ulp", 32'((res >= 32'h3EAA_AAA9) && (res <= 32'h3EAA_AAAD)), 32'd1);
    check("third_flags", 32'(flg), 32'd0);
    tick();

    // Stall in DONE for 5 cycles, with an ignored request in the middle
    i_ready = 1'b0;
    run(32'h40C0_0000, 32'h4000_0000, lat, held_res, held_flg);
    check("hold_res0", held_res, 32'h4040_0000);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        i_a = 32'h3F80_0000; i_b = 32'h0000_0000; i_valid = 1'b1;
      end
      tick();
      i_valid = 1'b0;
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_ready", 32'(o_ready), 32'd0);
      check("hold_res",   o_result, held_res);
      check("hold_flags", 32'(o_flags), 32'(held_flg));
    end
    i_ready = 1'b1;
    tick();
    check("handoff_valid", 32'(o_valid), 32'd0);
    check("handoff_ready", 32'(o_ready), 32'd1);
    tick();
    tick();
    check("ignored_req", 32'(o_valid), 32'd0);

    // Reset while in NR_SUB: accept at edge 0, NR_SUB after edge 2
    i_a = 32'h40C0_0000; i_b = 32'h4000_0000; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd1);
    tick();
    tick();
    check("midrst_no_res", 32'(o_valid), 32'd0);
    vec("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 9);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
